// File: rtl/rtc_access_sequencer.sv
// Burst sequencer in front of the RTC bus-timing stage: walks the time registers
// (read or write + transfer command), owns the muxed AD bus and publishes an atomic snapshot.
module rtc_access_sequencer #(
  parameter int          N_REGS    = 6,
  parameter logic [7:0]  BASE_ADDR = 8'h21,
  parameter bit          XFER_EN   = 1'b1,
  parameter logic [7:0]  XFER_ADDR = 8'hF0,
  parameter logic [7:0]  XFER_DATA = 8'hF0,
  parameter logic [5:0]  TIMEOUT   = 6'd63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_all,
  input  logic                  wr_all,
  input  logic [8*N_REGS-1:0]   wr_time,
  input  logic                  frw,
  input  logic                  ad_n,
  input  logic                  cs_n,
  input  logic                  rd_n,
  output logic                  acceso,
  output logic                  read,
  output logic [7:0]            bus_out,
  output logic                  bus_oe,
  input  logic [7:0]            bus_in,
  output logic [8*N_REGS-1:0]   time_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     mode_rd_q, mode_rd_d;
  logic                     xfer_q, xfer_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [5:0]               wd_q, wd_d;
  logic                     err_q, err_d;
  logic                     cs_prev_q, cs_prev_d;
  logic                     rd_low_q, rd_low_d;
  logic                     bus_oe_q, bus_oe_d;
  logic [7:0]               bus_out_q, bus_out_d;
  logic [N_REGS-1:0][7:0]   shadow_q, shadow_d;
  logic [8*N_REGS-1:0]      time_q, time_d;

  logic                     abort;
  logic                     active;
  logic [7:0]               cur_addr;
  logic [7:0]               cur_wdata;

  always_comb begin
    state_d   = state_q;
    mode_rd_d = mode_rd_q;
    xfer_d    = xfer_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    err_d     = err_q;
    shadow_d  = shadow_q;
    time_d    = time_q;
    cs_prev_d = cs_n;
    rd_low_d  = (rd_n == 1'b0);
    abort     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_all) begin
          mode_rd_d = 1'b1;
          xfer_d    = 1'b0;
          idx_d     = '0;
          err_d     = 1'b0;
          state_d   = S_REQ;
        end else if (wr_all) begin
          mode_rd_d = 1'b0;
          xfer_d    = 1'b0;
          idx_d     = '0;
          err_d     = 1'b0;
          shadow_d  = wr_time;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (wd_q == TIMEOUT) abort = 1'b1;
        else if (!ad_n && !cs_n) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wd_q == TIMEOUT) begin
          abort = 1'b1;
        end else begin
          // Strobe-qualified capture: data is valid on the cs_n rising edge of a real read cycle.
          if (mode_rd_q && cs_n && !cs_prev_q && rd_low_q) shadow_d[idx_q] = bus_in;
          if (frw) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!xfer_q && idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REQ;
        end else if (!mode_rd_q && XFER_EN && !xfer_q) begin
          xfer_d  = 1'b1;
          state_d = S_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (mode_rd_q) time_d = shadow_q;
        xfer_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      err_d   = 1'b1;
      xfer_d  = 1'b0;
      state_d = S_IDLE;
    end

    // Watchdog restarts per access and spans both REQ and WAIT.
    if (state_d == S_REQ && state_q != S_REQ) wd_d = '0;
    else if (state_q == S_REQ || state_q == S_WAIT) wd_d = wd_q + 6'd1;
  end

  assign active    = (state_q != S_IDLE) && !abort;
  assign cur_addr  = xfer_q ? XFER_ADDR : BASE_ADDR + 8'(idx_q);
  assign cur_wdata = xfer_q ? XFER_DATA : shadow_q[idx_q];

  always_comb begin
    bus_oe_d  = 1'b0;
    bus_out_d = bus_out_q;
    if (active && !ad_n) begin
      bus_oe_d  = 1'b1;
      bus_out_d = cur_addr;
    end else if (active && !mode_rd_q && ad_n && !cs_n) begin
      bus_oe_d  = 1'b1;
      bus_out_d = cur_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_rd_q <= 1'b0;
      xfer_q    <= 1'b0;
      idx_q     <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      cs_prev_q <= 1'b1;
      rd_low_q  <= 1'b0;
      bus_oe_q  <= 1'b0;
      bus_out_q <= '0;
      shadow_q  <= '0;
      time_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_rd_q <= mode_rd_d;
      xfer_q    <= xfer_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      cs_prev_q <= cs_prev_d;
      rd_low_q  <= rd_low_d;
      bus_oe_q  <= bus_oe_d;
      bus_out_q <= bus_out_d;
      shadow_q  <= shadow_d;
      time_q    <= time_d;
    end
  end

  assign acceso   = (state_q == S_REQ);
  assign read     = (state_q != S_IDLE) && mode_rd_q && !xfer_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign bus_oe   = bus_oe_q;
  assign bus_out  = bus_out_q;
  assign time_out = time_q;

endmodule
